// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory macro.
// Round-robin between instruction fetch and data, with a fixed number of
// wait states per access and a data-side lock for multi-beat sequences.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  f_req,
   input  logic [ADDR_WIDTH-1:0] f_addr,
   output logic                  f_done,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic                  d_lock,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  gnt_fetch,
   output logic                  gnt_data,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0] state;
   logic [2:0] wait_cnt;
   logic       lock_active;
   logic       last_data;   // 1 when the data port won the previous arbitration
   logic       win;
   logic       pick_data;

   // IDLE-cycle winner: a held lock beats round-robin, otherwise the
   // port that did not win last time gets priority when both ask.
   always_comb begin
      win       = f_req | d_req;
      pick_data = 1'b0;
      if (lock_active && d_req) begin
         pick_data = 1'b1;
      end else if (d_req && !f_req) begin
         pick_data = 1'b1;
      end else if (d_req && f_req) begin
         pick_data = !last_data;
      end
   end

   // Arbitration FSM, memory-side registers and response generation.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         wait_cnt    <= 3'd0;
         lock_active <= 1'b0;
         last_data   <= 1'b0;
         f_done      <= 1'b0;
         d_done      <= 1'b0;
         rdata       <= '0;
         gnt_fetch   <= 1'b0;
         gnt_data    <= 1'b0;
         mem_cs      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // An abandoned lock is dropped here; the fetch branch below
               // may still win in this same cycle.
               if (lock_active && !d_req) begin
                  lock_active <= 1'b0;
               end
               if (win) begin
                  state     <= ST_ACCESS;
                  last_data <= pick_data;
                  mem_cs    <= 1'b1;
                  wait_cnt  <= 3'(WAIT_STATES);
                  gnt_data  <= pick_data;
                  gnt_fetch <= !pick_data;
                  if (pick_data) begin
                     mem_addr    <= d_addr;
                     mem_wdata   <= d_wdata;
                     mem_we      <= d_we;
                     lock_active <= d_lock;
                  end else begin
                     mem_addr <= f_addr;
                     mem_we   <= 1'b0;
                  end
               end
            end
            ST_ACCESS: begin
               if (wait_cnt == 3'd0) begin
                  if (!mem_we) begin
                     rdata <= mem_rdata;
                  end
                  mem_cs    <= 1'b0;
                  mem_we    <= 1'b0;
                  gnt_fetch <= 1'b0;
                  gnt_data  <= 1'b0;
                  f_done    <= gnt_fetch;
                  d_done    <= gnt_data;
                  state     <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            ST_RESP: begin
               f_done <= 1'b0;
               d_done <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected
// transactions, a negedge monitor checks grants and completions.
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int WS = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          f_req = 1'b0;
   logic [AW-1:0] f_addr = '0;
   logic          f_done;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic          d_lock = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_done;
   logic [DW-1:0] rdata;
   logic          gnt_fetch, gnt_data;
   logic          mem_cs, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_done(f_done),
      .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_done(d_done), .rdata(rdata),
      .gnt_fetch(gnt_fetch), .gnt_data(gnt_data),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: preset contents, written while the DUT drives cs&we.
   logic [7:0] mem [256];
   bit mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hC3;
         mem[8'h10] <= 8'hA5;
         mem_ready  <= 1'b1;
      end else if (mem_cs && mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[7:0]];

   function automatic logic [7:0] mv(input logic [15:0] a);
      return (a == 16'h0010) ? 8'hA5 : (a[7:0] ^ 8'hC3);
   endfunction

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      bit          isd;
      bit          we;
      logic [15:0] a;
      logic [7:0]  wd;
      logic [7:0]  rd;
      int          dc;
      bit          ab;
   } exp_t;
   exp_t q[$];

   task automatic push(input bit isd, input bit we, input logic [15:0] a,
                       input logic [7:0] wd, input logic [7:0] rd, input int dc, input bit ab);
      exp_t e;
      e.isd = isd; e.we = we; e.a = a; e.wd = wd; e.rd = rd; e.dc = dc; e.ab = ab;
      q.push_back(e);
   endtask

   // Monitor: grants are compared with the head entry every ACCESS cycle,
   // completions pop the head and check owner, timing and read data.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (q.size() > 0 && q[0].ab) void'(q.pop_front());
      end else begin
         chk("cs_vs_gnt", {31'd0, mem_cs}, {31'd0, gnt_fetch | gnt_data});
         if (gnt_fetch || gnt_data) begin
            chk("gnt_excl", {31'd0, gnt_fetch & gnt_data}, 32'd0);
            chk("sb_has_grant_entry", {31'd0, q.size() > 0}, 32'd1);
            if (q.size() > 0) begin
               chk("gnt_port", {31'd0, gnt_data}, {31'd0, q[0].isd});
               chk("mem_addr", {16'd0, mem_addr}, {16'd0, q[0].a});
               chk("mem_we", {31'd0, mem_we}, {31'd0, q[0].we});
               if (q[0].we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, q[0].wd});
            end
         end
         if (f_done || d_done) begin
            chk("done_excl", {31'd0, f_done & d_done}, 32'd0);
            chk("sb_has_done_entry", {31'd0, q.size() > 0}, 32'd1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("done_port", {31'd0, d_done}, {31'd0, e.isd});
               chk("done_cycle", cyc, e.dc);
               chk("rdata", {24'd0, rdata}, {24'd0, e.rd});
            end
         end
      end
   end

   logic [15:0] d_a [8];
   logic        d_w [8];
   logic [7:0]  d_wd[8];
   logic        d_l [8];
   logic [15:0] f_a [8];

   // Drives nd data and nf fetch transactions from the tables; each
   // request is held and only advanced or dropped on its own done.
   task automatic run(input int nd, input int nf, input int budget);
      int di = 0;
      int fi = 0;
      if (nd > 0) begin
         d_req = 1'b1; d_addr = d_a[0]; d_we = d_w[0]; d_wdata = d_wd[0]; d_lock = d_l[0];
      end
      if (nf > 0) begin
         f_req = 1'b1; f_addr = f_a[0];
      end
      for (int k = 0; k < budget && (di < nd || fi < nf); k++) begin
         @(negedge clk);
         if (d_done) begin
            di++;
            if (di >= nd) d_req = 1'b0;
            else begin
               d_addr = d_a[di]; d_we = d_w[di]; d_wdata = d_wd[di]; d_lock = d_l[di];
            end
         end
         if (f_done) begin
            fi++;
            if (fi >= nf) f_req = 1'b0;
            else f_addr = f_a[fi];
         end
      end
      chk("run_completions", di + fi, nd + nf);
      d_req = 1'b0; f_req = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int c0;
      repeat (3) @(negedge clk);
      chk("rst_state_mem_cs", {31'd0, mem_cs}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      chk("rst_rdata", {24'd0, rdata}, 32'd0);
      chk("rst_dones", {30'd0, f_done, d_done}, 32'd0);
      chk("rst_gnts", {30'd0, gnt_fetch, gnt_data}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // 1: single fetch, rdata A5, done at cycle 3
      c0 = cyc;
      f_a[0] = 16'h0010;
      push(0, 0, 16'h0010, 8'h00, 8'hA5, c0 + 3, 0);
      run(0, 1, 20);
      @(negedge clk);

      // 2: simultaneous requests after reset, data goes first
      do_reset();
      c0 = cyc;
      d_a[0] = 16'h0020; d_w[0] = 1'b0; d_wd[0] = 8'h00; d_l[0] = 1'b0;
      f_a[0] = 16'h0030;
      push(1, 0, 16'h0020, 8'h00, mv(16'h0020), c0 + 3, 0);
      push(0, 0, 16'h0030, 8'h00, mv(16'h0030), c0 + 7, 0);
      run(1, 1, 30);
      @(negedge clk);

      // 3: both held for six transactions, strict alternation
      c0 = cyc;
      for (int i = 0; i < 3; i++) begin
         d_a[i] = 16'h0040 + 16'(i); d_w[i] = 1'b0; d_wd[i] = 8'h00; d_l[i] = 1'b0;
         f_a[i] = 16'h0050 + 16'(i);
         push(1, 0, d_a[i], 8'h00, mv(d_a[i]), c0 + 3 + 8 * i, 0);
         push(0, 0, f_a[i], 8'h00, mv(f_a[i]), c0 + 7 + 8 * i, 0);
      end
      run(3, 3, 60);
      @(negedge clk);

      // 4: locked two-beat write keeps fetch out until the second beat ends
      c0 = cyc;
      d_a[0] = 16'h00FF; d_w[0] = 1'b1; d_wd[0] = 8'h12; d_l[0] = 1'b1;
      d_a[1] = 16'h00FE; d_w[1] = 1'b1; d_wd[1] = 8'h34; d_l[1] = 1'b0;
      f_a[0] = 16'h0060;
      push(1, 1, 16'h00FF, 8'h12, mv(16'h0052), c0 + 3, 0);
      push(1, 1, 16'h00FE, 8'h34, mv(16'h0052), c0 + 7, 0);
      push(0, 0, 16'h0060, 8'h00, mv(16'h0060), c0 + 11, 0);
      run(2, 1, 40);
      chk("t4_mem_ff", {24'd0, mem[8'hFF]}, 32'h12);
      chk("t4_mem_fe", {24'd0, mem[8'hFE]}, 32'h34);
      @(negedge clk);

      // 5: locked beat, then data drops; fetch wins in that IDLE cycle
      c0 = cyc;
      d_a[0] = 16'h0070; d_w[0] = 1'b0; d_wd[0] = 8'h00; d_l[0] = 1'b1;
      f_a[0] = 16'h0071;
      push(1, 0, 16'h0070, 8'h00, mv(16'h0070), c0 + 3, 0);
      push(0, 0, 16'h0071, 8'h00, mv(16'h0071), c0 + 7, 0);
      run(1, 1, 30);
      d_lock = 1'b0;
      @(negedge clk);

      // 6: reset in the first ACCESS cycle of a write aborts it
      c0 = cyc;
      push(1, 1, 16'h0080, 8'hAB, 8'h00, 0, 1);
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0080; d_wdata = 8'hAB; d_lock = 1'b0;
      @(negedge clk);
      chk("t6_gnt_before_reset", {31'd0, gnt_data}, 32'd1);
      reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("t6_mem_cs", {31'd0, mem_cs}, 32'd0);
      chk("t6_mem_we", {31'd0, mem_we}, 32'd0);
      chk("t6_gnt_data", {31'd0, gnt_data}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      chk("t6_rdata_cleared", {24'd0, rdata}, 32'd0);
      c0 = cyc;
      f_a[0] = 16'h0090;
      push(0, 0, 16'h0090, 8'h00, mv(16'h0090), c0 + 3, 0);
      run(0, 1, 20);
      repeat (3) @(negedge clk);
      chk("sb_drained", q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
